// File: rtl/mcu_ctrl.sv
// mcu_ctrl: write-enable sequencer for the N+2 column memories of the conv datapath.
// Ports: clk, rst (async low), i_sop/i_eop/i_chblk in; o_we, o_state, o_substate, o_memSelect out.
module mcu_ctrl #(
  parameter int N      = 2,
  parameter int STATES = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_sop,
  input  logic                       i_eop,
  input  logic                       i_chblk,
  output logic [N+1:0]               o_we,
  output logic [$clog2(STATES)-1:0]  o_state,
  output logic [$clog2(N/2+1)-1:0]   o_substate,
  output logic [$clog2(N+2)-1:0]     o_memSelect
);

  localparam int SW  = $clog2(STATES);
  localparam int PW  = $clog2(N+2);
  localparam int CW  = $clog2(N+3);
  localparam int SSW = $clog2(N/2+1);

  localparam logic [PW-1:0]  P_LAST   = PW'(N+1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(N+2);
  localparam logic [SSW-1:0] SUB_LAST = SSW'(N/2);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [PW-1:0]  wr_ptr, wr_n;
  logic [CW-1:0]  load_cnt, cnt_n;
  logic [SSW-1:0] substate, sub_n;
  logic [PW-1:0]  mem_sel, sel_n;
  logic           chblk_q;
  logic           chblk_edge;
  logic           load_full;
  logic [N+1:0]   we_hot;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == P_LAST) ? '0 : p + 1'b1;
  endfunction

  assign chblk_edge = i_chblk & ~chblk_q;
  assign load_full  = (load_cnt == CNT_FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= LOAD;
      wr_ptr   <= '0;
      load_cnt <= '0;
      substate <= '0;
      mem_sel  <= '0;
      chblk_q  <= 1'b0;
    end else begin
      state    <= state_n;
      wr_ptr   <= wr_n;
      load_cnt <= cnt_n;
      substate <= sub_n;
      mem_sel  <= sel_n;
      chblk_q  <= i_chblk;
    end
  end

  always_comb begin
    state_n = state;
    wr_n    = wr_ptr;
    cnt_n   = load_cnt;
    sub_n   = substate;
    sel_n   = mem_sel;
    case (state)
      LOAD: begin
        if (!load_full) begin
          if (chblk_edge) begin
            wr_n  = inc(wr_ptr);
            cnt_n = load_cnt + 1'b1;
          end
        end else if (i_sop) begin
          state_n = RUN;
          cnt_n   = '0;
        end
      end
      RUN: begin
        if (i_eop) begin
          state_n = UPDATE;
          sub_n   = '0;
        end
      end
      UPDATE: begin
        if (chblk_edge) begin
          wr_n  = inc(wr_ptr);
          sel_n = inc(mem_sel);
          if (substate == SUB_LAST) begin
            sub_n   = '0;
            state_n = LOAD;
            cnt_n   = '0;
          end else begin
            sub_n = substate + 1'b1;
          end
        end
      end
      default: state_n = LOAD;
    endcase
  end

  assign we_hot = {{(N+1){1'b0}}, 1'b1} << wr_ptr;

  always_comb begin
    o_we = '0;
    if (state == UPDATE || (state == LOAD && !load_full))
      o_we = we_hot;
  end

  assign o_state     = SW'(state);
  assign o_substate  = substate;
  assign o_memSelect = mem_sel;

endmodule

// File: tb/tb_mcu_ctrl.sv
// tb_mcu_ctrl: directed bench for mcu_ctrl with N=2.
// Drives framing strobes 1ns after the rising edge and checks outputs there.
module tb_mcu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_sop;
  logic       i_eop;
  logic       i_chblk;
  logic [3:0] o_we;
  logic [1:0] o_state;
  logic [0:0] o_substate;
  logic [1:0] o_memSelect;

  int n_pass = 0;
  int n_chk  = 0;

  mcu_ctrl #(.N(2), .STATES(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_sop       (i_sop),
    .i_eop       (i_eop),
    .i_chblk     (i_chblk),
    .o_we        (o_we),
    .o_state     (o_state),
    .o_substate  (o_substate),
    .o_memSelect (o_memSelect)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    i_chblk = 1'b1;
    tick(2);
    i_chblk = 1'b0;
    tick(2);
  endtask

  task automatic all4(
    input string      tag,
    input logic [3:0] we,
    input logic [1:0] st,
    input logic [0:0] sub,
    input logic [1:0] sel
  );
    chk({tag, ".we"}, 32'(o_we), 32'(we));
    chk({tag, ".state"}, 32'(o_state), 32'(st));
    chk({tag, ".sub"}, 32'(o_substate), 32'(sub));
    chk({tag, ".sel"}, 32'(o_memSelect), 32'(sel));
  endtask

  task automatic frame_load(input string tag);
    pulse();
    pulse();
    pulse();
    pulse();
    chk({tag, ".full_we"}, 32'(o_we), 32'h0);
  endtask

  initial begin
    rst     = 1'b0;
    i_sop   = 1'b0;
    i_eop   = 1'b0;
    i_chblk = 1'b0;
    tick(2);
    all4("rst_hold", 4'b0001, 2'd0, 1'b0, 2'd0);
    rst = 1'b1;
    tick(3);
    all4("rst_idle", 4'b0001, 2'd0, 1'b0, 2'd0);

    pulse();
    chk("ld1_we", 32'(o_we), 32'b0010);
    pulse();
    chk("ld2_we", 32'(o_we), 32'b0100);
    i_sop = 1'b1;
    tick(2);
    chk("early_sop", 32'(o_state), 32'd0);
    i_sop = 1'b0;
    tick(1);
    pulse();
    chk("ld3_we", 32'(o_we), 32'b1000);
    pulse();
    chk("ld4_we", 32'(o_we), 32'b0000);
    pulse();
    all4("ld5_ign", 4'b0000, 2'd0, 1'b0, 2'd0);

    i_sop = 1'b1;
    tick(1);
    chk("run_state", 32'(o_state), 32'd1);
    chk("run_we", 32'(o_we), 32'h0);
    i_sop = 1'b0;
    pulse();
    chk("run_chblk", 32'(o_state), 32'd1);
    chk("run_we2", 32'(o_we), 32'h0);

    i_sop = 1'b1;
    i_eop = 1'b1;
    tick(1);
    all4("upd_enter", 4'b0001, 2'd2, 1'b0, 2'd0);
    i_sop = 1'b0;
    tick(2);
    chk("upd_eop_ign", 32'(o_state), 32'd2);
    i_eop = 1'b0;
    tick(1);

    pulse();
    all4("upd1", 4'b0010, 2'd2, 1'b1, 2'd1);
    pulse();
    all4("upd2", 4'b0100, 2'd0, 1'b0, 2'd2);

    pulse();
    chk("f2_ld1", 32'(o_we), 32'b1000);
    pulse();
    chk("f2_ld2", 32'(o_we), 32'b0001);
    pulse();
    chk("f2_ld3", 32'(o_we), 32'b0010);
    pulse();
    chk("f2_ld4", 32'(o_we), 32'b0000);

    i_sop = 1'b1;
    tick(1);
    chk("f2_run", 32'(o_state), 32'd1);
    i_sop = 1'b0;
    i_eop = 1'b1;
    tick(1);
    all4("f2_upd", 4'b0100, 2'd2, 1'b0, 2'd2);
    i_eop = 1'b0;
    pulse();
    all4("f2_upd1", 4'b1000, 2'd2, 1'b1, 2'd3);
    pulse();
    all4("f2_wrap", 4'b0001, 2'd0, 1'b0, 2'd0);

    frame_load("f3");
    i_sop = 1'b1;
    tick(1);
    i_sop = 1'b0;
    i_eop = 1'b1;
    tick(1);
    i_eop = 1'b0;
    pulse();
    all4("f3_upd1", 4'b0010, 2'd2, 1'b1, 2'd1);

    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    all4("async_rst", 4'b0001, 2'd0, 1'b0, 2'd0);
    tick(1);
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mcu_ctrl.md
Name: mcu_ctrl

Overview:
- Memory control unit (MCU) sequencer for the 2D-convolution datapath.
- Rotates write-enables across N+2 column memories while an input frame is loaded.
- Reports the current phase (state, substate) and the index of the oldest memory in the convolution window (o_memSelect) to the read/convolution logic.
- Driven by host framing strobes: start-of-processing, end-of-processing and "change block" (memory block full).

Parameters:
- N, 2, kernel-related memory count; the block controls N+2 memories. Must be even, ≥2.
- STATES, 3, number of FSM states; sets o_state width.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous reset, active-low: rst=0 resets immediately.
- i_sop  in  1  start of processing, level.
- i_eop  in  1  end of processing, level.
- i_chblk  in  1  change-block strobe, level; only its rising edge is used.
- o_we  out  N+2  one-hot write enable per memory, or all-zero.
- o_state  out  clog2(STATES)  current FSM state.
- o_substate  out  clog2(N/2+1)  block counter while in UPDATE.
- o_memSelect  out  clog2(N+2)  index of the oldest memory in the window.

Behaviour:
- Internal registers:
  - state, range 0..2.
  - wr_ptr, range 0..N+1.
  - load_cnt, range 0..N+2.
  - substate, range 0..N/2.
  - memSel, range 0..N+1.
  - chblk_q, previous sample of i_chblk.
- Change-block edge: chblk_edge = i_chblk & ~chblk_q, evaluated each clock.
  - An edge sampled at clock k updates the registers at that edge; the outputs change right after it (1-cycle latency from input to output).
  - A level held high for several cycles counts once.
- Reset (rst=0, asynchronous):
  - state=0 (LOAD), wr_ptr=0, load_cnt=0, substate=0, memSel=0, chblk_q=0.
  - Resulting outputs: o_we = 1 (bit 0 set), o_state=0, o_substate=0, o_memSelect=0.
  - Reset mid-operation aborts any state and returns to these values.
- Output decode:
  - o_we = one-hot(wr_ptr) in LOAD while load_cnt < N+2, and in UPDATE.
  - o_we = 0 otherwise.
  - o_state = state; o_substate = substate; o_memSelect = memSel.
- State 0 LOAD (initial frame fill):
  - Each chblk_edge while load_cnt < N+2: wr_ptr = (wr_ptr+1) mod (N+2), load_cnt += 1.
  - When load_cnt = N+2, o_we = 0, and further edges are ignored.
  - i_sop=1 while load_cnt = N+2: go to RUN and clear load_cnt.
  - i_sop=1 before the load completes is ignored.
  - i_eop is ignored in LOAD.
- State 1 RUN (convolution active):
  - o_we=0; chblk edges are ignored; i_sop level is ignored.
  - i_eop=1: go to UPDATE with substate=0.
  - i_eop has priority if i_sop and i_eop are both high.
- State 2 UPDATE (refill of N/2+1 blocks):
  - Each chblk_edge:
    - wr_ptr = (wr_ptr+1) mod (N+2).
    - memSel = (memSel+1) mod (N+2).
    - If substate < N/2: substate += 1.
    - If substate = N/2: substate = 0, state = LOAD, load_cnt = 0.
  - i_sop and i_eop are ignored in UPDATE; UPDATE does not time out.
- Wrap-around: all pointer increments wrap from N+1 to 0.
- Unused encodings of state (value 3) go to LOAD on the next clock.

Test Plan:
- Reset: hold rst=0 → o_state=0, o_we=4'b0001, o_memSelect=0, o_substate=0 (N=2). Outputs stay so after rst=1 with no stimulus.
- Initial load:
  - Five i_chblk pulses, each 2 cycles high and 2 cycles low.
  - → o_we goes 0001→0010→0100→1000→0000; the 5th pulse has no effect; o_state=0.
  - A pulse held high 2 cycles advances exactly once.
- Start:
  - i_sop=1 before the 4th pulse → o_state stays 0.
  - i_sop=1 after load complete → o_state=1 one cycle later, o_we=0.
- End with refill:
  - In RUN, i_eop=1 → o_state=2, o_we=0001 (wr_ptr wrapped to 0).
  - 1st chblk → o_we=0010, o_memSelect=1, o_substate=1.
  - 2nd chblk → o_state=0, o_substate=0, o_memSelect=2, o_we=0100.
- Second frame:
  - Four more pulses → o_we returns to 0000, with wr_ptr passing 3→0→1→2.
  - i_sop → RUN; i_eop → UPDATE; o_memSelect advances to 3 and then wraps to 0.
- Asynchronous reset in UPDATE: rst=0 mid-cycle → all outputs return to reset values immediately, without waiting for a clock edge.
